// File: rtl/clock_gate_pkg.sv
// Shared types and sizing helpers for the gated-clock enable sequencer.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } cg_state_t;

    function automatic int unsigned cg_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both wake settle and idle hold-off, so size it for the longer one.
    function automatic int unsigned cg_cnt_width(input int unsigned wake_cycles,
                                                 input int unsigned hold_cycles);
        return $clog2(cg_max(wake_cycles, hold_cycles) + 1);
    endfunction

endpackage

// File: rtl/cg_down_counter.sv
// Loadable down-counter that saturates at zero; shared by the wake and hold phases.
module cg_down_counter
    import clock_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/clock_gate_sequencer.sv
// Gate-enable sequencer for one gated clock domain: OFF -> WAKE -> ON -> HOLD -> OFF.
// Optional build macro CLKGATE_FORCE_EN adds i_force_on to hold the domain awake.
module clock_gate_sequencer
    import clock_gate_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
`ifdef CLKGATE_FORCE_EN
    input  logic               i_force_on,
`endif
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_ack,
    output logic               o_gate_en,
    output logic               o_busy,
    output logic [1:0]         o_state
);

    localparam int unsigned   CNT_W     = cg_cnt_width(WAKE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    cg_state_t          r_state;
    cg_state_t          w_state_next;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_ack_next;
    logic               r_gate_en;
    logic               r_busy;
    logic               w_force;
    logic               w_want;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_load_val;
    logic               w_cnt_dec;
    logic               w_cnt_zero;

`ifdef CLKGATE_FORCE_EN
    assign w_force = i_force_on;
`else
    assign w_force = 1'b0;
`endif

    // Force behaves like an extra requester for sequencing but is never granted an ack.
    assign w_want = (|i_req) | w_force;

    cg_down_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_next   = r_state;
        w_ack_next     = '0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = WAKE_LOAD;
        w_cnt_dec      = 1'b0;
        unique case (r_state)
            OFF: begin
                if (w_want) begin
                    w_state_next   = WAKE;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = WAKE_LOAD;
                end
            end
            WAKE: begin
                // A request dropped during wake does not abort; ON then HOLD clean up.
                if (w_cnt_zero) begin
                    w_state_next = ON;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ON: begin
                w_ack_next = i_req;
                if (!w_want) begin
                    w_state_next   = HOLD;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (w_want) begin
                    w_state_next = ON;
                end else if (w_cnt_zero) begin
                    w_state_next = OFF;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_next = OFF;
            end
        endcase
    end

    // Outputs come straight from flops so the gate enable cannot glitch.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= OFF;
            r_ack     <= '0;
            r_gate_en <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ack     <= w_ack_next;
            r_gate_en <= (w_state_next != OFF);
            r_busy    <= (w_state_next != OFF);
        end
    end

    assign o_ack     = r_ack;
    assign o_gate_en = r_gate_en;
    assign o_busy    = r_busy;
    assign o_state   = r_state;

`ifndef SYNTHESIS
    a_ack_only_on: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (r_ack != '0) |-> (r_state == ON));
    a_gate_tracks_state: assert property (@(posedge i_clk) disable iff (!i_rstn)
        r_gate_en == (r_state != OFF));
`endif

endmodule

// File: tb/tb_clock_gate_sequencer.sv
// Scoreboard bench for clock_gate_sequencer: directed scenarios plus randomized requesters.
`timescale 1ns/1ps
module tb_clock_gate_sequencer;
    import clock_gate_pkg::*;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned WAKE_CYCLES = 4;
    localparam int unsigned HOLD_CYCLES = 8;

    logic               clk      = 1'b0;
    logic               rstn     = 1'b0;
    logic               force_on = 1'b0;
    logic [NUM_REQ-1:0] req      = '0;
    logic [NUM_REQ-1:0] ack;
    logic               gate_en;
    logic               busy;
    logic [1:0]         state;

    always #5 clk = ~clk;

    clock_gate_sequencer #(
        .NUM_REQ     (NUM_REQ),
        .WAKE_CYCLES (WAKE_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
`ifdef CLKGATE_FORCE_EN
        .i_force_on (force_on),
`endif
        .i_req      (req),
        .o_ack      (ack),
        .o_gate_en  (gate_en),
        .o_busy     (busy),
        .o_state    (state)
    );

    typedef struct packed {
        logic [1:0]         st;
        logic               gate;
        logic               bsy;
        logic [NUM_REQ-1:0] ak;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase plus elapsed-cycle timers counting up from phase entry.
    int                 m_phase = 0;   // 0 asleep, 1 waking, 2 granted, 3 idle hold-off
    int                 m_age   = 0;
    logic [NUM_REQ-1:0] m_ack   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_age   = 0;
        m_ack   = '0;
    endtask

    task automatic model_edge();
        bit want;
        want = (req != '0) || force_on;
        if (!rstn) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    m_ack = '0;
                    if (want) begin m_phase = 1; m_age = 1; end
                end
                1: begin
                    m_ack = '0;
                    if (m_age >= int'(WAKE_CYCLES)) m_phase = 2;
                    else m_age++;
                end
                2: begin
                    m_ack = req;
                    if (!want) begin m_phase = 3; m_age = 1; end
                end
                default: begin
                    m_ack = '0;
                    if (want) m_phase = 2;
                    else if (m_age >= int'(HOLD_CYCLES)) m_phase = 0;
                    else m_age++;
                end
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st   = 2'(m_phase);
        e.gate = (m_phase != 0);
        e.bsy  = (m_phase != 0);
        e.ak   = m_ack;
        return e;
    endfunction

    // One clock: advance the model on the edge and queue what the DUT must show.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        sb_q.push_back(model_out());
    endtask

    // Entered just after a step; asserts reset between edges and checks its immediate effect.
    task automatic do_reset();
        #1;
        rstn = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        check("async_rst_state", 32'(state), 32'(0));
        check("async_rst_gate", 32'(gate_en), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_ack", 32'(ack), 32'(0));
    endtask

    // mode 0: wait for ack == pat; mode 1: wait for gate_en low. Bounded.
    task automatic wait_for(input string name, input int mode, input logic [NUM_REQ-1:0] pat,
                            input int exp_cycles);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < 50) begin
            step();
            n++;
            if (mode == 0) hit = (ack === pat);
            else           hit = (gate_en === 1'b0);
        end
        check(name, hit ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_cycles));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_state", 32'(state), 32'(e.st));
                check("sb_gate_en", 32'(gate_en), 32'(e.gate));
                check("sb_busy", 32'(busy), 32'(e.bsy));
                check("sb_ack", 32'(ack), 32'(e.ak));
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [NUM_REQ-1:0] pats [4];
        bit quiet;
        pats = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        quiet = 1'b0;

        #2;
        check("por_state", 32'(state), 32'(0));
        check("por_gate", 32'(gate_en), 32'(0));
        check("por_ack", 32'(ack), 32'(0));
        step();
        step();
        rstn = 1'b1;
        step();

        // Reset mid-wake
        req = 4'b0001;
        step();
        step();
        check("wake_before_rst", 32'(state), 32'(WAKE));
        do_reset();
        req = '0;
        step();
        step();
        rstn = 1'b1;
        step();

        // Single request: wake latency and hold-off latency
        req = 4'b0001;
        wait_for("wake_to_ack", 0, 4'b0001, int'(WAKE_CYCLES) + 2);
        step();
        step();
        req = '0;
        step();
        check("ack_fall", 32'(ack), 32'(0));
        wait_for("drop_to_gate_off", 1, '0, int'(HOLD_CYCLES));
        check("off_after_hold", 32'(state), 32'(OFF));

        // Re-request in HOLD cycle 5
        req = 4'b0001;
        wait_for("wake_to_ack_2", 0, 4'b0001, int'(WAKE_CYCLES) + 2);
        req = '0;
        repeat (5) step();
        check("in_hold", 32'(state), 32'(HOLD));
        req = 4'b0010;
        step();
        check("hold_to_on", 32'(state), 32'(ON));
        check("hold_gate_kept", 32'(gate_en), 32'(1));
        step();
        check("rereq_ack", 32'(ack), 32'(4'b0010));
        req = '0;
        wait_for("rereq_gate_off", 1, '0, int'(HOLD_CYCLES) + 1);

        // Request arriving on the final hold cycle wins over expiry
        req = 4'b0001;
        wait_for("wake_to_ack_3", 0, 4'b0001, int'(WAKE_CYCLES) + 2);
        req = '0;
        repeat (HOLD_CYCLES) step();
        check("hold_last", 32'(state), 32'(HOLD));
        req = 4'b0100;
        step();
        check("collide_on", 32'(state), 32'(ON));
        check("collide_gate", 32'(gate_en), 32'(1));
        step();
        check("collide_ack", 32'(ack), 32'(4'b0100));
        req = '0;
        wait_for("collide_gate_off", 1, '0, int'(HOLD_CYCLES) + 1);

        // All requesters, released one per cycle
        req = 4'b1111;
        wait_for("multi_wake", 0, 4'b1111, int'(WAKE_CYCLES) + 2);
        for (int i = 0; i < 4; i++) begin
            req = pats[i];
            step();
            check("multi_ack", 32'(ack), 32'(pats[i]));
            check("multi_state", 32'(state), (pats[i] == '0) ? 32'(HOLD) : 32'(ON));
        end
        wait_for("multi_gate_off", 1, '0, int'(HOLD_CYCLES));

`ifdef CLKGATE_FORCE_EN
        force_on = 1'b1;
        step();
        check("force_gate_on", 32'(gate_en), 32'(1));
        repeat (30) step();
        check("force_state_on", 32'(state), 32'(ON));
        check("force_no_ack", 32'(ack), 32'(0));
        force_on = 1'b0;
        wait_for("force_release_off", 1, '0, int'(HOLD_CYCLES) + 1);
`endif

        // Randomized requesters obeying the handshake against the model's acks
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) quiet = ~quiet;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && !m_ack[i] && ($urandom_range(quiet ? 40 : 3, 0) == 0))
                    req[i] = 1'b1;
                else if (req[i] && m_ack[i] && ($urandom_range(2, 0) == 0))
                    req[i] = 1'b0;
            end
`ifdef CLKGATE_FORCE_EN
            if ($urandom_range(40, 0) == 0) force_on = ~force_on;
`endif
            if ($urandom_range(600, 0) == 0) begin
                do_reset();
                req      = '0;
                force_on = 1'b0;
                step();
                rstn = 1'b1;
            end
            step();
        end

        req      = '0;
        force_on = 1'b0;
        repeat (20) step();
        check("final_off", 32'(state), 32'(OFF));
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
